// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage.
//   INST_BYTES       : bytes per instruction word (PC stride)
//   DEFAULT_RESET_PC : default reset PC when the parent does not override it
//   cnt_width()      : width of a counter that must hold 0..depth inclusive
package fetch_unit_pkg;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} entries for the fetch stage.
//   i_clk, i_rst_n : clock and synchronous active-low reset
//   push, wdata    : write one entry (caller guarantees not full)
//   pop            : retire the head entry (caller guarantees not empty)
//   clear          : drop all entries (used on branch redirect)
//   rdata          : head entry, valid whenever !empty
//   full, empty, count : occupancy status
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            clear,
  input  logic [WIDTH-1:0]                wdata,
  output logic [WIDTH-1:0]                rdata,
  output logic                            full,
  output logic                            empty,
  output logic [cnt_width(DEPTH)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge i_clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Clocked instruction-fetch stage with its own PC, up to DEPTH in-order
// outstanding memory requests and a prefetch FIFO feeding decode.
//   i_clk, i_rst_n                : clock, synchronous active-low reset
//   i_b_taken, i_b_pc             : branch redirect strobe and target
//   o_mem_req_valid/_addr, i_mem_req_ready : request channel to instruction memory
//   i_mem_resp_valid/_data        : in-order response, one per accepted request
//   o_valid, i_ready              : decode-side handshake
//   o_pc, o_inst, o_pc_next       : head entry (zero when the FIFO is empty)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned      DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_b_taken,
  input  logic [XLEN-1:0] i_b_pc,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_resp_valid,
  input  logic [XLEN-1:0] i_mem_resp_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc_next
);

  localparam int unsigned     CW   = cnt_width(DEPTH);
  localparam int unsigned     EW   = 2 * XLEN;
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [EW-1:0]   fifo_rdata;

  logic            credit_ok;
  logic            req_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;
  logic            head_vis;
  logic [XLEN-1:0] head_pc;

  // Issue only while every possible response is guaranteed a FIFO slot.
  assign credit_ok = (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));

  assign o_mem_req_valid = i_rst_n && !i_b_taken && credit_ok;
  assign o_mem_req_addr  = i_rst_n ? fetch_pc : RESET_PC;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_fire = i_mem_resp_valid && (outstanding != '0);
  assign push      = resp_fire && (drop == '0) && !i_b_taken && !fifo_full;

  assign head_vis  = i_rst_n && !fifo_empty;
  assign o_valid   = head_vis && !i_b_taken;
  assign pop       = o_valid && i_ready;

  assign head_pc   = fifo_rdata[EW-1:XLEN];
  assign o_pc      = head_vis ? head_pc               : '0;
  assign o_inst    = head_vis ? fifo_rdata[XLEN-1:0]  : '0;
  assign o_pc_next = head_vis ? head_pc + STEP        : '0;

  // PC tracking, in-flight accounting and stale-response drop counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
      if (i_b_taken) begin
        fetch_pc <= i_b_pc;
        resp_pc  <= i_b_pc;
        // Everything still in flight after this edge belongs to the old path.
        drop     <= outstanding - CW'(resp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push)     resp_pc  <= resp_pc + STEP;
        if (resp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (i_b_taken),
    .wdata   ({resp_pc, i_mem_resp_data}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
